audio_sound_scheduler: RTL

Arbitrates game sound-effect requests (ball hit, cushion, pocket, foul, ...) onto the single sine-table phase counter in the audio path. Grants one requester at a time by fixed priority, with preemption by higher priority. Generates the per-sample step enable that advances the table index at the granted tone's rate, and times each sound's duration from a 1 ms tick.

---
 rtl/audio_sound_scheduler.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/audio_sound_scheduler.sv
// Fixed-priority sound-effect scheduler with preemption and retrigger. It drives the
// audio phase-counter step enable and times each sound from a 1 ms tick.
module audio_sound_scheduler #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DIV_WIDTH = 16,
  parameter int unsigned DUR_WIDTH = 10
) (
  input  logic                           clk,
  input  logic                           resetN,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DIV_WIDTH-1:0]   div_val,
  input  logic [NUM_REQ*DUR_WIDTH-1:0]   dur_val,
  input  logic                           tick_1ms,
  input  logic                           mute,
  output logic                           addr_en,
  output logic                           sound_on,
  output logic [$clog2(NUM_REQ)-1:0]     active_id,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           done,
  output logic                           busy
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

  state_t                 state_q, state_d;
  logic [NUM_REQ-1:0]     pending_q, pending_d;
  logic [ID_W-1:0]        sel_q, sel_d;
  logic [ID_W-1:0]        active_id_d;
  logic [DIV_WIDTH-1:0]   div_cnt_q, div_cnt_d;
  logic [DUR_WIDTH-1:0]   dur_cnt_q, dur_cnt_d;
  logic [NUM_REQ-1:0]     grant_d;
  logic                   addr_en_d, sound_on_d, done_d, busy_d;

  logic [DIV_WIDTH-1:0]   div_arr [NUM_REQ];
  logic [DUR_WIDTH-1:0]   dur_arr [NUM_REQ];
  logic [ID_W-1:0]        low_idx;
  logic                   any_pend;
  logic [NUM_REQ-1:0]     set_mask;
  logic                   expire;

  // A divider of zero steps every cycle, same as a divider of one.
  function automatic logic [DIV_WIDTH-1:0] div_reload(input logic [DIV_WIDTH-1:0] d);
    return (d == '0) ? '0 : d - DIV_WIDTH'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      div_arr[i] = div_val[i*DIV_WIDTH +: DIV_WIDTH];
      dur_arr[i] = dur_val[i*DUR_WIDTH +: DUR_WIDTH];
    end
  end

  // Lowest pending index is the highest-priority waiting requester.
  always_comb begin
    low_idx  = '0;
    any_pend = |pending_q;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (pending_q[i]) low_idx = ID_W'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    active_id_d = active_id;
    div_cnt_d   = div_cnt_q;
    dur_cnt_d   = dur_cnt_q;
    expire      = 1'b0;
    set_mask    = req;
    if (state_q == PLAY) set_mask[active_id] = 1'b0;
    pending_d   = pending_q | set_mask;

    case (state_q)
      IDLE: begin
        if (any_pend) begin
          sel_d   = low_idx;
          state_d = LOAD;
        end
      end
      LOAD: begin
        active_id_d      = sel_q;
        div_cnt_d        = div_reload(div_arr[sel_q]);
        dur_cnt_d        = dur_arr[sel_q];
        pending_d[sel_q] = 1'b0;
        state_d          = (dur_arr[sel_q] == '0) ? GAP : PLAY;
      end
      PLAY: begin
        if (div_cnt_q == '0) div_cnt_d = div_reload(div_arr[active_id]);
        else                 div_cnt_d = div_cnt_q - DIV_WIDTH'(1);
        // Retrigger restarts the duration only; the tone phase keeps running.
        if (req[active_id]) begin
          dur_cnt_d = dur_arr[active_id];
        end else if (tick_1ms) begin
          if (dur_cnt_q <= DUR_WIDTH'(1)) expire = 1'b1;
          else                            dur_cnt_d = dur_cnt_q - DUR_WIDTH'(1);
        end
        if (any_pend && (low_idx < active_id)) begin
          sel_d   = low_idx;
          state_d = LOAD;
        end else if (expire) begin
          state_d = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    grant_d    = (state_d == LOAD) ? (NUM_REQ'(1) << sel_d) : '0;
    addr_en_d  = (state_d == PLAY) && (div_cnt_d == '0) && !mute;
    sound_on_d = (state_d == PLAY) && !mute;
    done_d     = (state_d == GAP);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q   <= IDLE;
      pending_q <= '0;
      sel_q     <= '0;
      div_cnt_q <= '0;
      dur_cnt_q <= '0;
      active_id <= '0;
      grant     <= '0;
      addr_en   <= 1'b0;
      sound_on  <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      sel_q     <= sel_d;
      div_cnt_q <= div_cnt_d;
      dur_cnt_q <= dur_cnt_d;
      active_id <= active_id_d;
      grant     <= grant_d;
      addr_en   <= addr_en_d;
      sound_on  <= sound_on_d;
      done      <= done_d;
      busy      <= busy_d;
    end
  end

endmodule
